uart_baud_gen: RTL and testbench

Parametrised baud-tick generator for the UART/LoRa serial links. It has two independent channels. The TX channel emits one tick per bit period. The RX channel emits a mid-bit sample tick and can be re-phased on each detected start edge. The divisor is runtime-programmable with a fractional part, so one bitstream serves any baud rate from any system clock. It sits between the register/config logic and the UART TX/RX shift engines.

---
 rtl/uart_baud_gen_if.sv | 40 ++++
 rtl/uart_baud_gen.sv | 99 +++++++++
 tb/tb_uart_baud_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_if.sv
// Config and tick signals between the register/config block (master)
// and the baud-tick generator (slave).
interface uart_baud_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              cfg_we;
    logic [DIV_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              cfg_err;
    logic              tx_en;
    logic              tx_tick;
    logic              rx_en;
    logic              rx_sync;
    logic              rx_mid_tick;

    modport master (
        output cfg_we,
        output cfg_div_int,
        output cfg_div_frac,
        output tx_en,
        output rx_en,
        output rx_sync,
        input  cfg_err,
        input  tx_tick,
        input  rx_mid_tick
    );

    modport slave (
        input  cfg_we,
        input  cfg_div_int,
        input  cfg_div_frac,
        input  tx_en,
        input  rx_en,
        input  rx_sync,
        output cfg_err,
        output tx_tick,
        output rx_mid_tick
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Two-channel fractional baud-tick generator: TX bit-boundary ticks and
// re-phasable RX mid-bit sample ticks from one programmable divisor.
module uart_baud_gen #(
    parameter int DIV_W          = 16,
    parameter int FRAC_W         = 4,
    parameter int RESET_DIV_INT  = 434,
    parameter int RESET_DIV_FRAC = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_baud_gen_if.slave bus
);
    localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RESET_DIV_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RESET_DIV_FRAC);

    logic [DIV_W-1:0]  div_int_q,  div_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d;
    logic              cfg_err_q,  cfg_err_d;
    logic              cfg_ok;
    logic [1:0]        chan_clr;
    logic [DIV_W-1:0]  mid_point;

    // The divisor may only change while both channels are stopped, so a
    // running period never sees a half-applied configuration.
    always_comb begin
        cfg_ok     = !bus.tx_en && !bus.rx_en && (bus.cfg_div_int >= DIV_W'(2));
        div_int_d  = div_int_q;
        div_frac_d = div_frac_q;
        cfg_err_d  = 1'b0;
        if (bus.cfg_we) begin
            if (cfg_ok) begin
                div_int_d  = bus.cfg_div_int;
                div_frac_d = bus.cfg_div_frac;
            end else begin
                cfg_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_int_q  <= RST_INT;
            div_frac_q <= RST_FRAC;
            cfg_err_q  <= 1'b0;
        end else begin
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign chan_clr[0] = !bus.tx_en;
    assign chan_clr[1] = !bus.rx_en || bus.rx_sync;

    // Channel 0 is TX, channel 1 is RX; they differ only in clear source
    // and in which count value is decoded as the output tick.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_chan
        logic [DIV_W-1:0]  cnt_q,   cnt_d;
        logic [FRAC_W-1:0] acc_q,   acc_d;
        logic              carry_q, carry_d;
        logic [DIV_W:0]    last_cnt;
        logic              wrap;

        // One extra bit keeps div_int = all-ones plus carry representable.
        always_comb begin
            last_cnt = {1'b0, div_int_q} + {{DIV_W{1'b0}}, carry_q}
                     - {{DIV_W{1'b0}}, 1'b1};
            wrap     = ({1'b0, cnt_q} == last_cnt);
            cnt_d    = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            acc_d    = acc_q;
            carry_d  = carry_q;
            if (chan_clr[gi]) begin
                cnt_d   = '0;
                acc_d   = '0;
                carry_d = 1'b0;
            end else if (wrap) begin
                cnt_d              = '0;
                {carry_d, acc_d}   = {1'b0, acc_q} + {1'b0, div_frac_q};
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                acc_q   <= '0;
                carry_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                acc_q   <= acc_d;
                carry_q <= carry_d;
            end
        end
    end

    assign mid_point       = div_int_q >> 1;
    assign bus.tx_tick     = gen_chan[0].wrap;
    assign bus.rx_mid_tick = (gen_chan[1].cnt_q == mid_point);
    assign bus.cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: directed scenarios plus random traffic, all
// checked every cycle against an event-level model of tick times.
module tb_uart_baud_gen;
    localparam int DIV_W   = 16;
    localparam int FRAC_W  = 4;
    localparam int RST_DIV = 434;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

    uart_baud_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W),
        .RESET_DIV_INT(RST_DIV), .RESET_DIV_FRAC(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: absolute cycle of each channel's next expected tick.
    int m_div, m_frac;
    bit tx_act, rx_act, err_pend;
    int tx_next, tx_k, rx_next, rx_k;
    bit exp_tx, exp_rx, exp_err;

    // Length of period k of a run: the first is div, later ones gain one
    // cycle whenever the running sum k*frac crosses a multiple of 2^FRAC_W.
    function automatic int period(int k);
        int extra;
        extra = 0;
        if (k > 0)
            extra = ((k * m_frac) >> FRAC_W) - (((k - 1) * m_frac) >> FRAC_W);
        return m_div + extra;
    endfunction

    task automatic model_reset();
        m_div = RST_DIV; m_frac = 0;
        tx_act = 0; rx_act = 0; err_pend = 0;
        tx_next = 0; tx_k = 0; rx_next = 0; rx_k = 0;
    endtask

    task automatic model_step();
        bit tick_tx, tick_rx;
        tick_tx  = tx_act && (tx_next == cyc);
        tick_rx  = rx_act && (rx_next == cyc);
        err_pend = bus.cfg_we && !(!bus.tx_en && !bus.rx_en && bus.cfg_div_int >= 2);
        if (!bus.tx_en) tx_act = 0;
        else if (!tx_act) begin tx_act = 1; tx_k = 0; tx_next = cyc + m_div - 1; end
        else if (tick_tx) begin tx_k++; tx_next += period(tx_k); end
        if (!bus.rx_en) rx_act = 0;
        else if (bus.rx_sync) begin rx_act = 1; rx_k = 0; rx_next = cyc + 1 + (m_div >> 1); end
        else if (!rx_act) begin rx_act = 1; rx_k = 0; rx_next = cyc + (m_div >> 1); end
        else if (tick_rx) begin rx_next += period(rx_k); rx_k++; end
        if (bus.cfg_we && !err_pend) begin
            m_div  = int'(bus.cfg_div_int);
            m_frac = int'(bus.cfg_div_frac);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        exp_tx  = tx_act && (tx_next == cyc);
        exp_rx  = rx_act && (rx_next == cyc);
        exp_err = err_pend;
    endtask

    task automatic advance();
        if (!rst_n) model_reset();
        else        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            checks += 3;
            if (bus.tx_tick !== 1'b0) begin errors++; $display("FAIL reset_tx cyc=%0d got=%b exp=0", cyc, bus.tx_tick); end
            if (bus.rx_mid_tick !== 1'b0) begin errors++; $display("FAIL reset_rx cyc=%0d got=%b exp=0", cyc, bus.rx_mid_tick); end
            if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err cyc=%0d got=%b exp=0", cyc, bus.cfg_err); end
            advance();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample();
            checks += 3;
            if (bus.tx_tick !== exp_tx) begin errors++; $display("FAIL idle_tx cyc=%0d got=%b exp=%b", cyc, bus.tx_tick, exp_tx); end
            if (bus.rx_mid_tick !== exp_rx) begin errors++; $display("FAIL idle_rx cyc=%0d got=%b exp=%b", cyc, bus.rx_mid_tick, exp_rx); end
            if (bus.cfg_err !== exp_err) begin errors++; $display("FAIL idle_err cyc=%0d got=%b exp=%b", cyc, bus.cfg_err, exp_err); end
            advance();
        end
        $display("test_reset done cyc=%0d", cyc);
    endtask

    task automatic test_tx_default();
        int ticks[$];
        int t0;
        int exp_t[3] = '{433, 867, 1301};
        bus.tx_en = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 1305; i++) begin
            sample();
            checks += 3;
            if (bus.tx_tick !== exp_tx) begin errors++; $display("FAIL tx_tick cyc=%0d got=%b exp=%b", cyc, bus.tx_tick, exp_tx); end
            if (bus.rx_mid_tick !== exp_rx) begin errors++; $display("FAIL tx_rx cyc=%0d got=%b exp=%b", cyc, bus.rx_mid_tick, exp_rx); end
            if (bus.cfg_err !== exp_err) begin errors++; $display("FAIL tx_err cyc=%0d got=%b exp=%b", cyc, bus.cfg_err, exp_err); end
            if (bus.tx_tick === 1'b1) ticks.push_back(cyc - t0);
            advance();
        end
        bus.tx_en = 1'b0;
        while (ticks.size() < 3) ticks.push_back(-1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ticks[i] != exp_t[i]) begin errors++; $display("FAIL tx_default_tick%0d got=%0d exp=%0d", i, ticks[i], exp_t[i]); end
        end
        advance();
        $display("test_tx_default done ticks=%0d,%0d,%0d", ticks[0], ticks[1], ticks[2]);
    endtask

    task automatic test_rx_sync();
        bit hit[900];
        bus.rx_en = 1'b1;
        for (int i = 0; i < 900; i++) begin
            bus.rx_sync = (i == 100) || (i == 500);
            sample();
            checks += 3;
            if (bus.tx_tick !== exp_tx) begin errors++; $display("FAIL rxs_tx cyc=%0d got=%b exp=%b", cyc, bus.tx_tick, exp_tx); end
            if (bus.rx_mid_tick !== exp_rx) begin errors++; $display("FAIL rxs_mid cyc=%0d got=%b exp=%b", cyc, bus.rx_mid_tick, exp_rx); end
            if (bus.cfg_err !== exp_err) begin errors++; $display("FAIL rxs_err cyc=%0d got=%b exp=%b", cyc, bus.cfg_err, exp_err); end
            hit[i] = bus.rx_mid_tick;
            advance();
        end
        bus.rx_sync = 1'b0;
        bus.rx_en   = 1'b0;
        checks += 3;
        if (hit[318] !== 1'b1) begin errors++; $display("FAIL rx_mid_318 got=%b exp=1", hit[318]); end
        if (hit[718] !== 1'b1) begin errors++; $display("FAIL rx_mid_718 got=%b exp=1", hit[718]); end
        if (hit[752] !== 1'b0) begin errors++; $display("FAIL rx_mid_752 got=%b exp=0", hit[752]); end
        advance();
        $display("test_rx_sync done hit318=%b hit718=%b hit752=%b", hit[318], hit[718], hit[752]);
    endtask

    task automatic test_fraction();
        int ticks[$];
        int t0;
        int exp_d[4] = '{10, 11, 10, 11};
        bus.cfg_we = 1'b1; bus.cfg_div_int = 16'd10; bus.cfg_div_frac = 4'd8;
        sample();
        advance();
        bus.cfg_we = 1'b0;
        bus.tx_en  = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 800 && ticks.size() < 65; i++) begin
            sample();
            checks += 3;
            if (bus.tx_tick !== exp_tx) begin errors++; $display("FAIL frac_tx cyc=%0d got=%b exp=%b", cyc, bus.tx_tick, exp_tx); end
            if (bus.rx_mid_tick !== exp_rx) begin errors++; $display("FAIL frac_rx cyc=%0d got=%b exp=%b", cyc, bus.rx_mid_tick, exp_rx); end
            if (bus.cfg_err !== exp_err) begin errors++; $display("FAIL frac_err cyc=%0d got=%b exp=%b", cyc, bus.cfg_err, exp_err); end
            if (bus.tx_tick === 1'b1) ticks.push_back(cyc - t0);
            advance();
        end
        checks++;
        if (ticks.size() != 65) begin errors++; $display("FAIL frac_tick_count got=%0d exp=65", ticks.size()); end
        while (ticks.size() < 65) ticks.push_back(-1000);
        checks++;
        if (ticks[0] != 9) begin errors++; $display("FAIL frac_first got=%0d exp=9", ticks[0]); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ticks[i+1] - ticks[i] != exp_d[i]) begin errors++; $display("FAIL frac_gap%0d got=%0d exp=%0d", i + 1, ticks[i+1] - ticks[i], exp_d[i]); end
        end
        checks++;
        if (ticks[64] - ticks[0] != 672) begin errors++; $display("FAIL frac_64_periods got=%0d exp=672", ticks[64] - ticks[0]); end
        $display("test_fraction done span64=%0d", ticks[64] - ticks[0]);
    endtask

    task automatic test_cfg_err();
        int c_we, err_at, t0, first;
        // TX is still running at 10.5 from the previous scenario.
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                bus.tx_en = 1'b0;
                for (int i = 0; i < 3; i++) begin sample(); advance(); end
            end
            bus.cfg_we = 1'b1;
            bus.cfg_div_int  = (pass == 0) ? 16'd50 : 16'd1;
            bus.cfg_div_frac = 4'd3;
            c_we   = cyc;
            err_at = -1;
            sample();
            advance();
            bus.cfg_we = 1'b0;
            for (int i = 0; i < 40; i++) begin
                sample();
                checks += 3;
                if (bus.tx_tick !== exp_tx) begin errors++; $display("FAIL cfg_tx cyc=%0d got=%b exp=%b", cyc, bus.tx_tick, exp_tx); end
                if (bus.rx_mid_tick !== exp_rx) begin errors++; $display("FAIL cfg_rx cyc=%0d got=%b exp=%b", cyc, bus.rx_mid_tick, exp_rx); end
                if (bus.cfg_err !== exp_err) begin errors++; $display("FAIL cfg_err cyc=%0d got=%b exp=%b", cyc, bus.cfg_err, exp_err); end
                if (bus.cfg_err === 1'b1 && err_at < 0) err_at = cyc;
                advance();
            end
            checks++;
            if (err_at != c_we + 1) begin errors++; $display("FAIL cfg_err_cycle pass=%0d got=%0d exp=%0d", pass, err_at, c_we + 1); end
        end
        // Divisor must still be 10 after the rejected writes.
        t0 = cyc; first = -1;
        bus.tx_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            sample();
            checks++;
            if (bus.tx_tick !== exp_tx) begin errors++; $display("FAIL cfg_keep_tx cyc=%0d got=%b exp=%b", cyc, bus.tx_tick, exp_tx); end
            if (bus.tx_tick === 1'b1 && first < 0) first = cyc - t0;
            advance();
        end
        checks++;
        if (first != 9) begin errors++; $display("FAIL cfg_keep_first got=%0d exp=9", first); end
        bus.tx_en = 1'b0;
        advance();
        $display("test_cfg_err done first=%0d", first);
    endtask

    task automatic test_tx_disable();
        int nt, r, first;
        bus.cfg_we = 1'b1; bus.cfg_div_int = 16'd434; bus.cfg_div_frac = 4'd8;
        sample();
        advance();
        bus.cfg_we = 1'b0;
        bus.tx_en  = 1'b1;
        nt = 0;
        // Run two periods (carry now set), then 200 cycles into the third.
        for (int i = 0; i < 1200 && nt < 2; i++) begin
            sample();
            checks++;
            if (bus.tx_tick !== exp_tx) begin errors++; $display("FAIL dis_tx cyc=%0d got=%b exp=%b", cyc, bus.tx_tick, exp_tx); end
            if (bus.tx_tick === 1'b1) nt++;
            advance();
        end
        for (int i = 0; i < 200; i++) begin
            sample();
            checks++;
            if (bus.tx_tick !== exp_tx) begin errors++; $display("FAIL dis_run_tx cyc=%0d got=%b exp=%b", cyc, bus.tx_tick, exp_tx); end
            advance();
        end
        bus.tx_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            checks++;
            if (bus.tx_tick !== 1'b0) begin errors++; $display("FAIL dis_idle_tx cyc=%0d got=%b exp=0", cyc, bus.tx_tick); end
            advance();
        end
        bus.tx_en = 1'b1;
        r = cyc; first = -1;
        for (int i = 0; i < 500 && first < 0; i++) begin
            sample();
            checks++;
            if (bus.tx_tick !== exp_tx) begin errors++; $display("FAIL dis_re_tx cyc=%0d got=%b exp=%b", cyc, bus.tx_tick, exp_tx); end
            if (bus.tx_tick === 1'b1) first = cyc - r;
            advance();
        end
        checks++;
        if (first != 433) begin errors++; $display("FAIL dis_reenable_first got=%0d exp=433", first); end
        bus.tx_en = 1'b0;
        advance();
        $display("test_tx_disable done first=%0d", first);
    endtask

    task automatic test_reset_midrun();
        bit found;
        int r;
        int ticks[$];
        bus.cfg_we = 1'b1; bus.cfg_div_int = 16'd10; bus.cfg_div_frac = 4'd0;
        sample();
        advance();
        bus.cfg_we = 1'b0;
        bus.tx_en = 1'b1; bus.rx_en = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            sample();
            checks += 2;
            if (bus.tx_tick !== exp_tx) begin errors++; $display("FAIL mid_tx cyc=%0d got=%b exp=%b", cyc, bus.tx_tick, exp_tx); end
            if (bus.rx_mid_tick !== exp_rx) begin errors++; $display("FAIL mid_rx cyc=%0d got=%b exp=%b", cyc, bus.rx_mid_tick, exp_rx); end
            if (exp_tx && i >= 20) begin found = 1; break; end
            advance();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_no_tick got=0 exp=1"); end
        // Assert reset mid-cycle while a tick is being decoded.
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.tx_tick !== 1'b0) begin errors++; $display("FAIL rst_async_tx got=%b exp=0", bus.tx_tick); end
        if (bus.rx_mid_tick !== 1'b0) begin errors++; $display("FAIL rst_async_rx got=%b exp=0", bus.rx_mid_tick); end
        if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_async_err got=%b exp=0", bus.cfg_err); end
        advance();
        for (int i = 0; i < 2; i++) begin sample(); advance(); end
        rst_n = 1'b1;
        r = cyc;
        for (int i = 0; i < 900; i++) begin
            sample();
            checks += 2;
            if (bus.tx_tick !== exp_tx) begin errors++; $display("FAIL post_rst_tx cyc=%0d got=%b exp=%b", cyc, bus.tx_tick, exp_tx); end
            if (bus.rx_mid_tick !== exp_rx) begin errors++; $display("FAIL post_rst_rx cyc=%0d got=%b exp=%b", cyc, bus.rx_mid_tick, exp_rx); end
            if (bus.tx_tick === 1'b1) ticks.push_back(cyc - r);
            advance();
        end
        while (ticks.size() < 2) ticks.push_back(-1);
        checks += 2;
        if (ticks[0] != 433) begin errors++; $display("FAIL post_rst_first got=%0d exp=433", ticks[0]); end
        if (ticks[1] - ticks[0] != 434) begin errors++; $display("FAIL post_rst_gap got=%0d exp=434", ticks[1] - ticks[0]); end
        bus.tx_en = 1'b0; bus.rx_en = 1'b0;
        advance();
        $display("test_reset_midrun done first=%0d", ticks[0]);
    endtask

    task automatic test_random();
        bus.cfg_we = 1'b1;
        bus.cfg_div_int  = 16'($urandom_range(2, 24));
        bus.cfg_div_frac = 4'($urandom_range(0, 15));
        sample();
        advance();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) bus.tx_en = ~bus.tx_en;
            if ($urandom_range(0, 149) == 0) bus.rx_en = ~bus.rx_en;
            bus.rx_sync = ($urandom_range(0, 19) == 0);
            bus.cfg_we  = ($urandom_range(0, 39) == 0);
            bus.cfg_div_int  = 16'($urandom_range(0, 24));
            bus.cfg_div_frac = 4'($urandom_range(0, 15));
            sample();
            checks += 3;
            if (bus.tx_tick !== exp_tx) begin errors++; $display("FAIL rnd_tx cyc=%0d got=%b exp=%b", cyc, bus.tx_tick, exp_tx); end
            if (bus.rx_mid_tick !== exp_rx) begin errors++; $display("FAIL rnd_rx cyc=%0d got=%b exp=%b", cyc, bus.rx_mid_tick, exp_rx); end
            if (bus.cfg_err !== exp_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bus.cfg_err, exp_err); end
            advance();
        end
        bus.tx_en = 1'b0; bus.rx_en = 1'b0; bus.rx_sync = 1'b0; bus.cfg_we = 1'b0;
        advance();
        $display("test_random done cyc=%0d div=%0d frac=%0d", cyc, m_div, m_frac);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_div_int = '0; bus.cfg_div_frac = '0;
        bus.tx_en = 1'b0; bus.rx_en = 1'b0; bus.rx_sync = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_tx_default();
        test_rx_sync();
        test_fraction();
        test_cfg_err();
        test_tx_disable();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
